// File: rtl/stepper_seq_ctrl.sv
// stepper_seq_ctrl: 4-coil wave/full/half-step sequencer with counted moves, abort and signed position.
// Build option STEP_HOLD_EN: keep the last energised pattern on the coils while idle.
module stepper_seq_ctrl #(
    parameter int DIV_W = 20,
    parameter int CNT_W = 16,
    parameter int POS_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [DIV_W-1:0]        period,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] pos,
    output logic [3:0]              coil
);
`ifdef STEP_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [7:0][3:0] PHASE = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                         4'b0110, 4'b0010, 4'b0011, 4'b0001};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [2:0]       idx, idx_nx, delta;
    logic [DIV_W-1:0] div, per_q, per_eff;
    logic [CNT_W-1:0] rem;
    logic             dir_q, accept, step_en, done_nx, term;

    assign per_eff   = (period == '0) ? DIV_ONE : period;
    assign term      = (div == per_q - DIV_ONE);
    // half-step moves by one; wave/full move by two once on their own parity, else one to snap onto it
    assign delta     = (mode == 2'b10 || idx[0] == (mode == 2'b00)) ? 3'd1 : 3'd2;
    assign idx_nx    = dir_q ? idx + delta : idx - delta;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);

    // Next state, command acceptance, step strobe and completion pulse.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step_en  = 1'b0;
        done_nx  = 1'b0;
        if (state == IDLE) begin
            accept   = cmd_valid;
            done_nx  = cmd_valid && (cmd_steps == '0);
            state_nx = (cmd_valid && cmd_steps != '0) ? RUN : IDLE;
        end else if (abort) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
        end else if (term) begin
            step_en  = 1'b1;
            done_nx  = (rem == CNT_ONE);
            state_nx = done_nx ? IDLE : RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Move datapath: divider, phase index, coil pattern, position and remaining count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            div   <= '0;
            per_q <= DIV_ONE;
            rem   <= '0;
            dir_q <= 1'b0;
            coil  <= '0;
            pos   <= '0;
            done  <= 1'b0;
        end else begin
            done <= done_nx;
            if (state == IDLE && !HOLD) coil <= '0;
            if (accept) begin
                dir_q <= cmd_dir;
                rem   <= cmd_steps;
                div   <= '0;
                per_q <= per_eff;
            end else if (step_en) begin
                div   <= '0;
                per_q <= per_eff;
                idx   <= idx_nx;
                coil  <= PHASE[idx_nx];
                pos   <= dir_q ? pos + POS_ONE : pos - POS_ONE;
                rem   <= rem - CNT_ONE;
            end else if (state == RUN) begin
                div <= div + DIV_ONE;
            end
        end
    end
endmodule
